// File: rtl/pair_triple_pkg.sv
// -----------------------------------------------------------------------------
// pair_triple_pkg
// Shared definitions for the pair/triple detector stimulus generator:
//   - state_e       : sweep FSM states
//   - NUM_PATTERNS  : number of 3-bit stimulus words in a sweep
//   - SETTLE_MIN/MAX: legal range of the SETTLE_CYCLES parameter
//   - CNT_W         : width of the settle counter (covers SETTLE_MAX)
// -----------------------------------------------------------------------------
package pair_triple_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int NUM_PATTERNS = 8;
    localparam int SETTLE_MIN   = 1;
    localparam int SETTLE_MAX   = 15;
    localparam int CNT_W        = 4;

endpackage : pair_triple_pkg

// File: rtl/pair_triple_ref.sv
// -----------------------------------------------------------------------------
// pair_triple_ref
// Combinational golden model of the detector under test: expected_o is 1 when
// at least two of the three pattern bits are set (2-of-3 majority).
// Ports:
//   pattern_i  [2:0]  stimulus word currently driven
//   expected_o        required detector response for pattern_i
// -----------------------------------------------------------------------------
module pair_triple_ref (
    input  logic [2:0] pattern_i,
    output logic       expected_o
);

    assign expected_o = (pattern_i[0] & pattern_i[1]) |
                        (pattern_i[1] & pattern_i[2]) |
                        (pattern_i[0] & pattern_i[2]);

endmodule : pair_triple_ref

// File: rtl/pair_triple_stimulus.sv
// -----------------------------------------------------------------------------
// pair_triple_stimulus
// Sweeps all eight 3-bit patterns into a pair/triple detector, holds each for
// SETTLE_CYCLES cycles, samples the detector response once and records
// mismatches against the pair_triple_ref golden model.
//
// Parameters:
//   SETTLE_CYCLES  cycles each pattern is held before sampling (1..15)
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   start        single-cycle sweep request (accepted in IDLE or DONE)
//   det_in       detector response
//   pattern      stimulus word
//   pattern_vld  high while a pattern is being driven (DRIVE/SAMPLE)
//   busy         high from sweep acceptance until DONE entry
//   done         high while in DONE
//   pass         done with no mismatches
//   err_cnt      number of mismatching patterns (0..8)
//   fail_mask    bit i set when pattern i mismatched
// Configuration:
//   PAIR_TRIPLE_STIMULUS_STOP_ON_FAIL_EN  when defined, the sweep ends at the
//   first mismatch with pattern holding the failing value.
// -----------------------------------------------------------------------------
module pair_triple_stimulus
    import pair_triple_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       det_in,
    output logic [2:0] pattern,
    output logic       pattern_vld,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_mask
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       PATTERN_LAST = 3'(NUM_PATTERNS - 1);

    state_e           state_q, state_d;
    logic [2:0]       pattern_q, pattern_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       err_q, err_d;
    logic [7:0]       mask_q, mask_d;

    logic expected;
    logic mismatch;

    pair_triple_ref u_ref (
        .pattern_i  (pattern_q),
        .expected_o (expected)
    );

    // Only meaningful in SAMPLE; the FSM ignores it elsewhere.
    assign mismatch = (det_in != expected);

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
        end
    end

    // NOTE: every next-state signal gets a hold default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mask_d    = mask_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_DRIVE;
                    pattern_d = '0;
                    cnt_d     = '0;
                    err_d     = '0;
                    mask_d    = '0;
                end
            end

            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                // At most one increment per pattern, so err_cnt tops out at 8.
                if (mismatch) begin
                    err_d             = err_q + 4'd1;
                    mask_d[pattern_q] = 1'b1;
                end
`ifdef PAIR_TRIPLE_STIMULUS_STOP_ON_FAIL_EN
                if (mismatch || (pattern_q == PATTERN_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    pattern_d = pattern_q + 3'd1;
                    state_d   = ST_DRIVE;
                end
`else
                if (pattern_q == PATTERN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pattern_d = pattern_q + 3'd1;
                    state_d   = ST_DRIVE;
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign pattern     = pattern_q;
    assign busy        = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign pattern_vld = busy;
    assign done        = (state_q == ST_DONE);
    assign pass        = done && (err_q == 4'd0);
    assign err_cnt     = err_q;
    assign fail_mask   = mask_q;

endmodule : pair_triple_stimulus

// File: tb/tb_pair_triple_stimulus.sv
// -----------------------------------------------------------------------------
// tb_pair_triple_stimulus
// Directed bench for pair_triple_stimulus (SETTLE_CYCLES=2, sweep = 24 cycles).
// det_in comes from a selectable detector model: correct, stuck-at-0 or
// stuck-at-1. Expected values are hand-computed constants.
// Honours PAIR_TRIPLE_STIMULUS_STOP_ON_FAIL_EN the same way as the RTL build.
// -----------------------------------------------------------------------------
module tb_pair_triple_stimulus;

    logic       clk;
    logic       rst;
    logic       start;
    logic       det_in;
    logic [2:0] pattern;
    logic       pattern_vld;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic [7:0] fail_mask;

    int total = 0;
    int bad   = 0;
    int mode  = 0;  // 0: correct detector, 1: stuck at 0, 2: stuck at 1

    pair_triple_stimulus #(.SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .det_in      (det_in),
        .pattern     (pattern),
        .pattern_vld (pattern_vld),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_cnt     (err_cnt),
        .fail_mask   (fail_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        det_in = 1'b0;
        case (mode)
            0: det_in = (pattern[0] & pattern[1]) | (pattern[1] & pattern[2]) |
                        (pattern[0] & pattern[2]);
            2: det_in = 1'b1;
            default: det_in = 1'b0;
        endcase
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every output at zero, as in IDLE after reset.
    task automatic check_idle(input string tag);
        check({tag, ".pattern"},   32'(pattern),     32'h0);
        check({tag, ".vld"},       32'(pattern_vld), 32'h0);
        check({tag, ".busy"},      32'(busy),        32'h0);
        check({tag, ".done"},      32'(done),        32'h0);
        check({tag, ".pass"},      32'(pass),        32'h0);
        check({tag, ".err_cnt"},   32'(err_cnt),     32'h0);
        check({tag, ".fail_mask"}, 32'(fail_mask),   32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("idle");

        // ---- Sweep 1: correct detector, start at T, done at T+25 ----
        start = 1'b1;               // cycle T
        tick();                     // T+1
        start = 1'b0;
        check("s1.busy_t1",    32'(busy),        32'h1);
        check("s1.vld_t1",     32'(pattern_vld), 32'h1);
        check("s1.pattern_t1", 32'(pattern),     32'h0);
        repeat (3) tick();          // T+4
        check("s1.pattern_t4", 32'(pattern),     32'h1);
        repeat (20) tick();         // T+24
        check("s1.done_t24",   32'(done),        32'h0);
        check("s1.pattern_t24", 32'(pattern),    32'h7);
        tick();                     // T+25
        check("s1.done_t25",   32'(done),        32'h1);
        check("s1.pass",       32'(pass),        32'h1);
        check("s1.err_cnt",    32'(err_cnt),     32'h0);
        check("s1.fail_mask",  32'(fail_mask),   32'h00);
        check("s1.busy_done",  32'(busy),        32'h0);
        check("s1.vld_done",   32'(pattern_vld), 32'h0);
        // det_in changing while in DONE must not disturb anything
        mode = 2;
        repeat (3) tick();
        check("s1.hold_done",  32'(done),        32'h1);
        check("s1.hold_pat",   32'(pattern),     32'h7);
        check("s1.hold_err",   32'(err_cnt),     32'h0);
        mode = 0;

`ifndef PAIR_TRIPLE_STIMULUS_STOP_ON_FAIL_EN
        // ---- Sweep 2: stuck at 0, restarted from DONE ----
        mode  = 1;
        start = 1'b1;
        tick();                     // T+1
        start = 1'b0;
        repeat (24) tick();         // T+25
        check("s0.done",       32'(done),        32'h1);
        check("s0.err_cnt",    32'(err_cnt),     32'h4);
        check("s0.fail_mask",  32'(fail_mask),   32'hE8);
        check("s0.pass",       32'(pass),        32'h0);

        // ---- Sweep 3: stuck at 1; restart clears previous results ----
        mode  = 2;
        start = 1'b1;
        tick();                     // T+1
        start = 1'b0;
        check("s3.clr_err",    32'(err_cnt),     32'h0);
        check("s3.clr_mask",   32'(fail_mask),   32'h00);
        check("s3.clr_done",   32'(done),        32'h0);
        repeat (24) tick();         // T+25
        check("st1.done",      32'(done),        32'h1);
        check("st1.err_cnt",   32'(err_cnt),     32'h4);
        check("st1.fail_mask", 32'(fail_mask),   32'h17);
        check("st1.pass",      32'(pass),        32'h0);
`else
        // ---- Stop-on-fail: stuck at 0 ends after pattern 3 sample ----
        mode  = 1;
        start = 1'b1;
        tick();                     // T+1
        start = 1'b0;
        check("sf.clr_err",    32'(err_cnt),     32'h0);
        repeat (11) tick();         // T+12, sample of pattern 3
        check("sf.done_t12",   32'(done),        32'h0);
        tick();                     // T+13
        check("sf.done_t13",   32'(done),        32'h1);
        check("sf.pattern",    32'(pattern),     32'h3);
        check("sf.err_cnt",    32'(err_cnt),     32'h1);
        check("sf.fail_mask",  32'(fail_mask),   32'h08);
        check("sf.pass",       32'(pass),        32'h0);
`endif

        // ---- Start pulsed mid-sweep is ignored ----
        mode  = 0;
        start = 1'b1;               // cycle T
        tick();                     // T+1
        start = 1'b0;
        check("ign.clr_err",   32'(err_cnt),     32'h0);
        repeat (4) tick();          // T+5
        start = 1'b1;
        tick();                     // T+6
        start = 1'b0;
        check("ign.pattern_t6", 32'(pattern),    32'h1);
        repeat (18) tick();         // T+24
        check("ign.done_t24",  32'(done),        32'h0);
        tick();                     // T+25
        check("ign.done_t25",  32'(done),        32'h1);
        check("ign.pass",      32'(pass),        32'h1);

        // ---- Reset mid-sweep ----
        mode  = 1;
        start = 1'b1;               // cycle T
        tick();                     // T+1
        start = 1'b0;
        repeat (9) tick();          // T+10
        check("rst.busy_pre",  32'(busy),        32'h1);
        rst = 1'b1;
        tick();                     // T+11
        rst = 1'b0;
        check_idle("rst.mid");

        // ---- Reset wins over start ----
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_idle("rst.prio");
        tick();
        check("rst.stay_idle", 32'(busy),        32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pair_triple_stimulus

// File: doc/pair_triple_stimulus.md
PAIR_TRIPLE_STIMULUS -- requirements
Module: pair_triple_stimulus

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15: cycles each pattern is held before sampling.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle request to run a full sweep.
REQ-005 SHALL have port det_in  input  1  response of the pair/triple detector under test.
REQ-006 SHALL have port pattern  output  3  stimulus word driven to the detector inputs.
REQ-007 SHALL have port pattern_vld  output  1  high while pattern is being driven.
REQ-008 SHALL have port busy  output  1  high from sweep acceptance until DONE entry.
REQ-009 SHALL have port done  output  1  level, high while in DONE.
REQ-010 SHALL have port pass  output  1  done and err_cnt==0.
REQ-011 SHALL have port err_cnt  output  4  number of mismatching patterns, 0..8.
REQ-012 SHALL have port fail_mask  output  8  bit i set when pattern i mismatched.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-014 SHALL move IDLE->DRIVE or DONE->DRIVE on start; pattern=0, err_cnt=0, fail_mask=0 on that transition.
REQ-015 SHALL ignore start while in DRIVE or SAMPLE.
REQ-016 SHALL hold pattern stable for exactly SETTLE_CYCLES cycles in DRIVE, then enter SAMPLE for one cycle.
REQ-017 SHALL in SAMPLE compare det_in with expected = 1 when at least two of the three pattern bits are 1, else 0.
REQ-018 SHALL on mismatch increment err_cnt and set fail_mask[pattern] in the SAMPLE cycle's next-state update.
REQ-019 SHALL after SAMPLE with pattern<7 increment pattern and return to DRIVE; with pattern==7 enter DONE.
REQ-020 SHALL sample det_in only in SAMPLE; det_in in other states has no effect.
REQ-021 SHALL produce sweep latency 8*(SETTLE_CYCLES+1) cycles: start at cycle T -> done high at T+1+8*(SETTLE_CYCLES+1).
REQ-022 SHALL keep pattern, err_cnt, fail_mask stable in DONE until next start or rst.
REQ-023 SHALL drive pattern_vld and busy high in DRIVE and SAMPLE, low in IDLE and DONE.
REQ-024 SHALL never wrap err_cnt; max value 8 by construction.

Reset
REQ-025 SHALL on rst (any state, including mid-sweep) enter IDLE on next edge with pattern=0, pattern_vld=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, settle counter=0.
REQ-026 SHALL give rst priority over start in the same cycle.

Configuration
REQ-027 SHALL support macro PAIR_TRIPLE_STIMULUS_STOP_ON_FAIL_EN.
REQ-028 SHALL with the macro defined enter DONE directly after the first mismatching SAMPLE, holding pattern at the failing value (err_cnt=1).
REQ-029 SHALL without the macro always sweep all eight patterns regardless of mismatches.

Structure
REQ-030 SHALL place the FSM state enum, NUM_PATTERNS=8 and SETTLE_CYCLES bounds in shared package pair_triple_pkg.
REQ-031 SHALL instantiate one sub-module pair_triple_ref: combinational golden model producing expected from pattern.
REQ-032 SHALL contain no other sub-modules; settle counter and FSM live in the top.

Verification
REQ-033 SHALL test: det_in driven by a correct detector model, SETTLE_CYCLES=2, start at T -> done=1 at T+25, pass=1, err_cnt=0, fail_mask=8'h00.
REQ-034 SHALL test: det_in stuck at 0 -> err_cnt=4, fail_mask=8'hE8, pass=0.
REQ-035 SHALL test: det_in stuck at 1 -> err_cnt=4, fail_mask=8'h17, pass=0.
REQ-036 SHALL test: start pulsed again at T+5 during sweep -> ignored, done still at T+25; start in DONE -> new sweep, err_cnt/fail_mask cleared.
REQ-037 SHALL test: rst asserted at T+10 -> next cycle IDLE, all outputs 0; rst and start together -> stays IDLE.
REQ-038 SHALL test with STOP_ON_FAIL_EN: det_in stuck at 0 -> done after pattern 3 sample, pattern=3, err_cnt=1, fail_mask=8'h08.
